// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction fetch queue
package ifq_pkg;
  localparam int XLEN_DEFAULT = 32;
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;
  localparam fetch_entry_t RESET_ENTRY = '0;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: fetch-side push and decode-side pop handshakes plus flush and occupancy
interface instr_fetch_queue_if #(parameter int XLEN = 32, parameter int DEPTH = 4);
  logic                     flush;
  logic                     push_valid;
  logic                     push_ready;
  logic [XLEN-1:0]          push_pc;
  logic [XLEN-1:0]          push_instr;
  logic                     pop_valid;
  logic                     pop_ready;
  logic [XLEN-1:0]          pop_pc;
  logic [XLEN-1:0]          pop_instr;
  logic [$clog2(DEPTH):0]   count;
  modport master (
    output flush, push_valid, push_pc, push_instr, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_instr, count
  );
  modport slave (
    input  flush, push_valid, push_pc, push_instr, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_instr, count
  );
endinterface

// File: rtl/ifq_storage.sv
// ifq_storage: DEPTH-entry register array, one write port, one async read port, sync clear
module ifq_storage
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);
  fetch_entry_t mem [DEPTH];
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_ENTRY;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: DEPTH-entry {pc, instr} FIFO between fetch and decode with flush redirect
// Define IFQ_BYPASS_EN to forward a push straight to the pop side while the queue is empty.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input logic                CLK,
  input logic                RST,
  instr_fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         empty, full, byp, push_fire, pop_fire;
  fetch_entry_t head;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
`ifdef IFQ_BYPASS_EN
  assign byp = empty & q.push_valid & ~q.flush;
`else
  assign byp = 1'b0;
`endif
  // a bypassed entry taken by decode in the same cycle never occupies a slot
  assign push_fire    = q.push_valid & ~full & ~(byp & q.pop_ready);
  assign pop_fire     = q.pop_ready & ~empty;
  assign q.push_ready = ~full;
  assign q.pop_valid  = ~empty | byp;
  assign q.pop_pc     = byp ? q.push_pc    : empty ? '0 : head.pc;
  assign q.pop_instr  = byp ? q.push_instr : empty ? '0 : head.instr;
  assign q.count      = wr_ptr - rd_ptr;
  always_ff @(posedge CLK) begin
    if (RST || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  ifq_storage #(.DEPTH(DEPTH)) u_storage (
    .CLK   (CLK),
    .RST   (RST),
    .we    (push_fire & ~q.flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ('{pc: q.push_pc, instr: q.push_instr}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed checks of the fetch queue at DEPTH=4
module tb_instr_fetch_queue;
  logic CLK = 1'b0;
  logic RST;
  int   vectors = 0;
  int   errors = 0;
  always #5 CLK = ~CLK;
  instr_fetch_queue_if #(.XLEN(32), .DEPTH(4)) q ();
  instr_fetch_queue #(.XLEN(32), .DEPTH(4)) dut (.CLK(CLK), .RST(RST), .q(q.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic set_push(input logic v, input logic [31:0] pc);
    q.push_valid = v;
    q.push_pc    = pc;
    q.push_instr = pc + 32'h13;
  endtask
  initial begin
    RST = 1'b1;
    q.flush = 1'b0;
    q.pop_ready = 1'b0;
    set_push(1'b0, 32'h0);
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk("rst_count", 32'(q.count), 32'd0);
    chk("rst_push_ready", 32'(q.push_ready), 32'd1);
    chk("rst_pop_valid", 32'(q.pop_valid), 32'd0);
    chk("rst_pop_pc", q.pop_pc, 32'h0);
    chk("rst_pop_instr", q.pop_instr, 32'h0);
`ifndef IFQ_BYPASS_EN
    set_push(1'b1, 32'h100);
    #1;
    chk("no_comb_path", 32'(q.pop_valid), 32'd0);
`endif
    // 1: single push shows up one cycle later
    set_push(1'b1, 32'h100);
    q.push_instr = 32'h00500093;
    tick();
    set_push(1'b0, 32'h0);
    #1;
    chk("t1_pop_valid", 32'(q.pop_valid), 32'd1);
    chk("t1_pop_pc", q.pop_pc, 32'h100);
    chk("t1_pop_instr", q.pop_instr, 32'h00500093);
    chk("t1_count", 32'(q.count), 32'd1);
    // 2: fill, overflow attempt, drain in order
    for (int i = 1; i < 4; i++) begin
      set_push(1'b1, 32'h100 + 32'(4 * i));
      tick();
    end
    set_push(1'b0, 32'h0);
    #1;
    chk("t2_full_count", 32'(q.count), 32'd4);
    chk("t2_push_ready", 32'(q.push_ready), 32'd0);
    set_push(1'b1, 32'h110);
    tick();
    set_push(1'b0, 32'h0);
    #1;
    chk("t2_ignored_count", 32'(q.count), 32'd4);
    q.pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_pop_pc", q.pop_pc, 32'h100 + 32'(4 * i));
      tick();
    end
    q.pop_ready = 1'b0;
    #1;
    chk("t2_empty_count", 32'(q.count), 32'd0);
    chk("t2_empty_valid", 32'(q.pop_valid), 32'd0);
    chk("t2_empty_pc", q.pop_pc, 32'h0);
    // 3: steady push+pop at occupancy 2, pointers wrap
    set_push(1'b1, 32'h200);
    tick();
    set_push(1'b1, 32'h204);
    tick();
    q.pop_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_push(1'b1, 32'h208 + 32'(4 * k));
      #1;
      chk("t3_count", 32'(q.count), 32'd2);
      chk("t3_pop_pc", q.pop_pc, 32'h200 + 32'(4 * k));
      tick();
    end
    q.pop_ready = 1'b0;
    set_push(1'b1, 32'h230);
    tick();
    set_push(1'b0, 32'h0);
    #1;
    chk("t4_count3", 32'(q.count), 32'd3);
    chk("t4_head_pc", q.pop_pc, 32'h228);
    // 4: flush beats a same-cycle push
    q.flush = 1'b1;
    set_push(1'b1, 32'h300);
    tick();
    q.flush = 1'b0;
    set_push(1'b0, 32'h0);
    #1;
    chk("t4_count", 32'(q.count), 32'd0);
    chk("t4_pop_valid", 32'(q.pop_valid), 32'd0);
    chk("t4_pop_pc", q.pop_pc, 32'h0);
    chk("t4_push_ready", 32'(q.push_ready), 32'd1);
    // 5: reset mid-stream while pushing
    set_push(1'b1, 32'h400);
    tick();
    set_push(1'b1, 32'h404);
    tick();
    set_push(1'b0, 32'h0);
    #1;
    chk("t5_pre_count", 32'(q.count), 32'd2);
    set_push(1'b1, 32'h408);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    set_push(1'b0, 32'h0);
    #1;
    chk("t5_count", 32'(q.count), 32'd0);
    chk("t5_pop_valid", 32'(q.pop_valid), 32'd0);
    chk("t5_pop_pc", q.pop_pc, 32'h0);
    chk("t5_pop_instr", q.pop_instr, 32'h0);
    chk("t5_push_ready", 32'(q.push_ready), 32'd1);
`ifdef IFQ_BYPASS_EN
    // 6: zero-latency forward through an empty queue
    set_push(1'b1, 32'h200);
    q.pop_ready = 1'b1;
    #1;
    chk("t6_pop_valid", 32'(q.pop_valid), 32'd1);
    chk("t6_pop_pc", q.pop_pc, 32'h200);
    chk("t6_pop_instr", q.pop_instr, 32'h213);
    tick();
    set_push(1'b0, 32'h0);
    q.pop_ready = 1'b0;
    #1;
    chk("t6_count", 32'(q.count), 32'd0);
    chk("t6_pop_valid_after", 32'(q.pop_valid), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
